// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: runs the six AES known-answer tests through one shared multi-cycle engine
module aes_kat_sequencer #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [5:0]   pass,
  output logic         fail,
  output logic         timeout,
  output logic         eng_start,
  output logic         eng_decrypt,
  output logic [1:0]   eng_ksize,
  output logic [255:0] eng_key,
  output logic [127:0] eng_din,
  input  logic         eng_done,
  input  logic [127:0] eng_dout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [127:0] P    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic [2:0]    idx, idx_nx;
  logic [CW-1:0] cnt;
  logic [127:0]  result;
  logic          go, last, expired, load;
  function automatic logic [127:0] ct_of(input logic [1:0] ks);
    return ks == 2'd0 ? C128 : ks == 2'd1 ? C192 : C256;
  endfunction
  function automatic logic [255:0] key_of(input logic [1:0] ks);
    return ks == 2'd0 ? {128'h000102030405060708090a0b0c0d0e0f, 128'h0} :
           ks == 2'd1 ? {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0} :
                        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  endfunction
  assign go      = start && (state == IDLE || state == DONE) && !abort;
  assign last    = idx == 3'd5;
  assign expired = cnt == CW'(TIMEOUT);
  assign idx_nx  = go ? 3'd0 : idx + 3'd1;
  // operands are loaded on entry to ISSUE so they are stable for the whole engine run
  assign load    = go || (state == NEXT && !last && !abort);
  assign busy      = state inside {ISSUE, WAIT, CHECK, NEXT};
  assign done      = state == DONE;
  assign fail      = done && pass != 6'h3f;
  assign eng_start = state == ISSUE;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else case (state)
      IDLE, DONE: state_nx = start ? ISSUE : state;
      ISSUE:      state_nx = WAIT;
      WAIT:       state_nx = eng_done ? CHECK : expired ? NEXT : WAIT;
      CHECK:      state_nx = NEXT;
      NEXT:       state_nx = last ? DONE : ISSUE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      cnt         <= '0;
      result      <= '0;
      pass        <= '0;
      timeout     <= 1'b0;
      eng_decrypt <= 1'b0;
      eng_ksize   <= '0;
      eng_key     <= '0;
      eng_din     <= '0;
    end else if (!abort) begin
      if (go) begin
        pass    <= '0;
        timeout <= 1'b0;
        idx     <= '0;
      end else if (state == NEXT && !last) idx <= idx_nx;
      if (load) begin
        eng_decrypt <= idx_nx[0];
        eng_ksize   <= idx_nx[2:1];
        eng_key     <= key_of(idx_nx[2:1]);
        eng_din     <= idx_nx[0] ? ct_of(idx_nx[2:1]) : P;
      end
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT && !eng_done && !expired) cnt <= cnt + 1'b1;
      if (state == WAIT && eng_done) result <= eng_dout;
      if (state == WAIT && !eng_done && expired) timeout <= 1'b1;
      if (state == CHECK) pass[idx] <= result == (idx[0] ? P : ct_of(idx[2:1]));
    end
  end
endmodule

// File: tb/tb_aes_kat_sequencer.sv
// tb_aes_kat_sequencer: scoreboard bench with a lookup-based AES engine model
module tb_aes_kat_sequencer;
  localparam int L = 12;
  localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] ct [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                           128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                           128'h8ea2b7ca516745bfeafc49904b496089};
  logic [255:0] ky [3] = '{256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000,
                           256'h000102030405060708090a0b0c0d0e0f10111213141516170000000000000000,
                           256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic busy, done, fail, timeout, eng_start, eng_decrypt;
  logic [5:0] pass;
  logic [1:0] eng_ksize;
  logic [255:0] eng_key;
  logic [127:0] eng_din;
  logic eng_done = 0;
  logic [127:0] eng_dout = '0;
  int vectors = 0, miscompares = 0, cyc = 0;
  int corrupt_t = -1, noans_t = -1;
  logic spur_en = 0;
  logic [386:0] exp_q [$];
  int starts [$];

  aes_kat_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .eng_start(eng_start),
    .eng_decrypt(eng_decrypt), .eng_ksize(eng_ksize), .eng_key(eng_key), .eng_din(eng_din),
    .eng_done(eng_done), .eng_dout(eng_dout)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [399:0] got, input logic [399:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [386:0] mk(input int i);
    logic [1:0] k;
    k = i[2:1];
    return {k, i[0], i[0] ? ct[k] : P, ky[k]};
  endfunction

  // engine model: answers L cycles after eng_start with the known-answer value if operands are right
  initial begin
    int wcnt, t;
    logic pend;
    logic [127:0] resp;
    pend = 0; wcnt = 0; resp = '0;
    forever begin
      @(negedge clk);
      eng_done = 0;
      if (!rst_n) pend = 0;
      if (pend) begin
        wcnt--;
        if (wcnt == 0) begin eng_done = 1; eng_dout = resp; pend = 0; end
      end
      if (rst_n && eng_start) begin
        t = {29'd0, eng_ksize, eng_decrypt};
        if (eng_decrypt) resp = (eng_din == ct[eng_ksize] && eng_key == ky[eng_ksize]) ? P : ~P;
        else resp = (eng_din == P && eng_key == ky[eng_ksize]) ? ct[eng_ksize] : ~ct[eng_ksize];
        if (t == corrupt_t) resp[0] = ~resp[0];
        pend = t != noans_t;
        wcnt = L;
        if (spur_en) begin eng_done = 1; eng_dout = ~resp; spur_en = 0; end
      end
    end
  end

  // launch monitor: every eng_start must match the next expected operand set
  initial forever begin
    @(negedge clk);
    if (rst_n && eng_start) begin
      starts.push_back(cyc);
      if (exp_q.size() == 0) check("extra_start", 400'(1), 400'(0));
      else check("launch", 400'({eng_ksize, eng_decrypt, eng_din, eng_key}), 400'(exp_q.pop_front()));
    end
  end

  task automatic run(input logic [5:0] xp, input logic xt, input int xlat, input int poke);
    int t0, n;
    exp_q.delete();
    starts.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(i));
    @(negedge clk); start = 1; t0 = cyc;
    @(negedge clk); start = 0;
    check("busy_rise", 400'({busy, eng_start}), 400'(2'b11));
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      start = n == poke;
    end
    start = 0;
    check("latency", 400'(cyc - t0), 400'(xlat));
    check("done", 400'({done, busy}), 400'(2'b10));
    check("pass", 400'(pass), 400'(xp));
    check("fail", 400'(fail), 400'(xp != 6'h3f));
    check("timeout", 400'(timeout), 400'(xt));
    check("q_empty", 400'(exp_q.size()), 400'(0));
  endtask

  task automatic wait_starts(input int k);
    int n;
    n = 0;
    while (starts.size() < k && n < 200) begin @(negedge clk); n++; end
    check("wait_start", 400'(starts.size() >= k), 400'(1));
  endtask

  initial begin
    #1;
    check("rst_out", 400'({busy, done, pass, fail, timeout, eng_start, eng_decrypt, eng_ksize}), 400'(0));
    check("rst_data", 400'({eng_key, eng_din}), 400'(0));
    @(negedge clk); @(negedge clk); rst_n = 1;
    @(negedge clk);
    // nominal run with spacing checks
    run(6'h3f, 0, 91, -1);
    for (int i = 1; i < 6; i++) check("spacing", 400'(starts[i] - starts[i-1]), 400'(15));
    repeat (3) @(negedge clk);
    check("done_held", 400'({done, pass}), 400'({1'b1, 6'h3f}));
    // corrupted D192
    corrupt_t = 3;
    run(6'h37, 0, 91, -1);
    corrupt_t = -1;
    // E256 never answers
    noans_t = 4;
    run(6'h2f, 1, 94, -1);
    check("to_len", 400'(starts[5] - starts[4]), 400'(18));
    noans_t = -1;
    // abort during WAIT of test 2
    exp_q.delete();
    starts.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i));
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    wait_starts(3);
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk); abort = 0;
    check("abort", 400'({busy, done, eng_start, pass}), 400'({3'b000, 6'h03}));
    repeat (L + 2) @(negedge clk);
    check("abort_idle", 400'({busy, done}), 400'(0));
    // start and abort together: abort wins
    start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    check("start_abort", 400'({busy, eng_start}), 400'(0));
    run(6'h3f, 0, 91, -1);
    // restart attempt while busy plus spurious done in ISSUE
    spur_en = 1;
    run(6'h3f, 0, 91, 40);
    // async reset mid-WAIT
    exp_q.delete();
    starts.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(i));
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    wait_starts(2);
    repeat (3) @(negedge clk);
    check("pre_rst", 400'({busy, pass}), 400'({1'b1, 6'h01}));
    #2 rst_n = 0;
    #1;
    check("async_rst", 400'({busy, done, pass, fail, timeout, eng_start, eng_decrypt, eng_ksize}), 400'(0));
    check("async_rst_data", 400'({eng_key, eng_din}), 400'(0));
    @(negedge clk); rst_n = 1;
    repeat (L + 4) @(negedge clk);
    check("post_rst", 400'({busy, done, eng_start, exp_q.size() == 0}), 400'(4'b0001));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_kat_sequencer.md
# aes_kat_sequencer

Sequencer that runs the six AES known-answer tests (encrypt and decrypt at 128, 192 and 256-bit keys) one at a time through a single shared, multi-cycle AES engine. It replaces six parallel combinational cores with one engine. It drives the engine over a start/done handshake, compares each result against a hard-coded expected value, and reports per-test pass flags plus an overall done/fail status. It sits between the system self-test trigger and the shared AES engine.

## Interface
- `TIMEOUT`, default 1023: maximum number of cycles to wait for `eng_done` per test before declaring that test failed.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to run the full test sequence. Sampled only in IDLE or DONE.
- `abort` input 1: synchronous abort back to IDLE. Takes priority over every other event except reset.
- `busy` output 1: high from the cycle after an accepted `start` until DONE or abort.
- `done` output 1: high in DONE, held until the next accepted `start`.
- `pass` output 6: per-test pass bits in the order [0]=E128, [1]=D128, [2]=E192, [3]=D192, [4]=E256, [5]=D256.
- `fail` output 1: high in DONE when `pass != 6'h3F`.
- `timeout` output 1: sticky; set when any test times out, cleared on accepted `start`.
- `eng_start` output 1: one-cycle pulse that launches the engine.
- `eng_decrypt` output 1: 0 = encrypt, 1 = decrypt.
- `eng_ksize` output 2: key size, 0=128, 1=192, 2=256.
- `eng_key` output 256: key, left-aligned; unused low bits are 0.
- `eng_din` output 128: input block.
- `eng_done` input 1: one-cycle completion pulse from the engine.
- `eng_dout` input 128: engine result, valid while `eng_done` is high.

## Operation
- Constants:
  - Plaintext P = 00112233445566778899aabbccddeeff.
  - Keys are 000102…0f (128), 000102…17 (192) and 000102…1f (256).
  - Expected ciphertexts: C128 = 69c4e0d86a7b0430d8cdb78070b4c55a, C192 = dda97ca4864cdfe06eaf70a0ec0d7191, C256 = 8ea2b7ca516745bfeafc49904b496089.
- Test index `idx` runs 0..5:
  - `eng_ksize = idx>>1`.
  - `eng_decrypt = idx[0]`.
  - Encrypt tests use `eng_din = P` and expect the matching C.
  - Decrypt tests use `eng_din` = the matching C constant and expect P. They do not depend on the preceding encrypt result.
- `eng_key`, `eng_din`, `eng_ksize` and `eng_decrypt` are registered. They are stable from the ISSUE cycle through the end of WAIT.
- FSM states: IDLE, ISSUE, WAIT, CHECK, NEXT, DONE.
  - IDLE/DONE: on `start`, clear `pass`, `timeout` and `idx`, then go to ISSUE.
  - ISSUE: assert `eng_start` for exactly one cycle, clear the wait counter, go to WAIT.
  - WAIT: on `eng_done`, capture `eng_dout` into the result register and go to CHECK. Otherwise, if the counter equals `TIMEOUT`, set `timeout`, leave `pass[idx]` at 0 and go to NEXT. Otherwise increment the counter.
  - CHECK: set `pass[idx]` = (result == expected[idx]), go to NEXT.
  - NEXT: if `idx == 5`, go to DONE; else increment `idx` and go to ISSUE.
- `eng_done` is ignored outside WAIT, including a pulse coincident with `eng_start`.
- `start` while `busy` is ignored.
- `abort` in any state goes to IDLE:
  - `busy` and `eng_start` drop the next cycle.
  - `done` stays 0.
  - `pass` retains its partial value.
- Wait counter width is clog2(`TIMEOUT`+1). It never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, `idx` 0, result register 0.
- `start` at cycle T → `busy` rises at T+1 (ISSUE), and `eng_start` is high at T+1.
- If the engine answers L cycles after `eng_start`, each test costs L+3 cycles (ISSUE, WAIT×L, CHECK, NEXT).
- `done` rises one cycle after the final NEXT, so total runtime is 6·(L+3) cycles after T, plus 1.
- On timeout, a test costs `TIMEOUT`+3 cycles.
- `start` and `abort` in the same cycle: `abort` wins and the FSM stays in IDLE.
- Reset asserted mid-sequence returns to the reset values immediately (asynchronous). The engine sees `eng_start` = 0 from then on.

## Test plan
- Behavioural engine with L=12 returning correct AES results; pulse `start` → six `eng_start` pulses spaced 15 cycles apart, then `done`=1, `pass`=6'h3F, `fail`=0, `timeout`=0, with `done` rising 91 cycles after `start`.
- Engine corrupts bit 0 of the result for test D192 only → `pass`=6'h37, `fail`=1, `timeout`=0.
- Engine never answers for E256 with `TIMEOUT`=15 → that test lasts 18 cycles, `timeout`=1, `pass[4]`=0, and the remaining tests still pass.
- `abort` during WAIT of test 2 → IDLE next cycle, `busy`=0, `done`=0, `pass`=6'h03. A new `start` then completes with 6'h3F.
- `start` pulsed while busy, plus a spurious `eng_done` in ISSUE → no restart, and the result is taken only from the WAIT-state pulse.
- `rst_n` asserted mid-WAIT → all outputs 0 asynchronously and the FSM in IDLE after release.
